uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter OVERSAMPLE, default 16: clk_16bd ticks per transmitted bit.
REQ-002 clk_16bd  input  1  16x baud clock; all state advances on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 valid  input  1  configuration write strobe.
REQ-005 address  input  4  configuration register select.
REQ-006 data  input  4  configuration write data.
REQ-007 ack  output  1  one-cycle pulse confirming an accepted configuration write.
REQ-008 frame  input  9  payload, LSB transmitted first; bits at and above frame_length are ignored.
REQ-009 frame_valid  input  1  payload request.
REQ-010 frame_ready  output  1  high when a payload can be accepted this cycle.
REQ-011 Tx  output  1  serial line; idle level high.
REQ-012 busy  output  1  high while a frame is on the line.

Function
REQ-013 Configuration registers SHALL be:
- parity_en: address 4'b1001, data[3].
- parity_type: address 4'b1010, data[3]; 0 = even, 1 = odd.
- stop_bits: address 4'b1011, data[3]; 0 = one stop bit, 1 = two stop bits.
- frame_length: address 4'b1100, value 5 + data, saturating at 9.
REQ-014 A configuration write SHALL be accepted only in IDLE when valid=1 and address is one of the four above.
- On acceptance, the register updates at that edge and ack is high for exactly the next cycle.
- Writes to unknown addresses, and writes while busy, SHALL be ignored with no ack.
REQ-015 frame_ready = (state == IDLE) && !valid; valid has priority over frame_valid in the same cycle.
REQ-016 A frame SHALL be accepted at an edge where frame_ready && frame_valid.
- frame and the current configuration are latched at that edge.
- Configuration changes after acceptance do not affect that frame.
REQ-017 States SHALL be IDLE -> START -> DATA -> PARITY (only if parity_en) -> STOP -> IDLE.
- Each bit is held on Tx for exactly OVERSAMPLE cycles, timed by a tick counter that resets on every bit boundary.
REQ-018 Tx SHALL be registered: low starting the cycle after acceptance (START), and high in IDLE.
REQ-019 DATA SHALL send frame[0] through frame[frame_length-1] in order, using a bit counter that wraps to 0 on leaving DATA.
REQ-020 The parity bit SHALL be the XOR of the transmitted data bits for even parity, and its inverse for odd parity.
REQ-021 STOP SHALL drive Tx high for OVERSAMPLE × (1 + stop_bits) cycles.
REQ-022 busy SHALL be high from the cycle after acceptance through the last STOP cycle.
REQ-023 Total busy length SHALL be OVERSAMPLE × (1 + frame_length + parity_en + 1 + stop_bits) cycles.
REQ-024 frame_ready SHALL return high in the first cycle after STOP; back-to-back frames are allowed with no idle bit between them.
REQ-025 frame_valid while busy SHALL be ignored; the frame is not queued.

Reset
REQ-026 While rst=0, the block SHALL asynchronously force:
- state = IDLE, Tx = 1, busy = 0, ack = 0, frame_ready = 1;
- tick and bit counters = 0;
- parity_en = 0, parity_type = 0, stop_bits = 0, frame_length = 8.
REQ-027 Reset mid-frame SHALL abort the frame with Tx high immediately and no partial resumption after reset.

Verification
REQ-028 Default configuration, frame = 9'h0A5:
- Tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then high for 16 cycles.
- busy is high for 160 cycles.
REQ-029 Write 1001/4'b1000, then 1010/4'b0000 (ack one cycle each), then send frame = 9'h007:
- even parity bit = 1; busy is high for 176 cycles.
REQ-030 Write 1100/4'h4 and 1011/4'b1000, then send frame = 9'h1FF:
- nine data bits all 1, stop high for 32 cycles, busy high for 192 cycles.
REQ-031 Write 1100/4'hF and 1001/1000 and 1010/1000 (odd), then send frame = 9'h000:
- frame_length = 9; parity bit = 1.
REQ-032 During a busy frame, pulse valid (1001/1000) and frame_valid:
- no ack; parity_en stays 0; the second frame is never sent.
- In IDLE, valid and frame_valid together: ack = 1, no frame starts.
REQ-033 Assert rst=0 midway through DATA:
- Tx = 1 and busy = 0 within the same cycle.
- After release, frame_length reads back as 8 (check by sending 9'h0A5 and observing 160 busy cycles).

Source files
------------

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Purpose  : Configurable UART transmitter clocked by a 16x baud clock.
//            A small register bank (parity enable/type, stop bits, frame
//            length) is written through a valid/address/data strobe. A
//            payload of 5..9 bits is latched together with the configuration
//            and shifted out LSB first as START, DATA, optional PARITY and
//            one or two STOP bits. Each bit lasts OVERSAMPLE clocks.
// Ports    : clk_16bd    - 16x baud clock, rising edge
//            rst         - asynchronous active-low reset
//            valid       - configuration write strobe
//            address[3:0]- configuration register select
//            data[3:0]   - configuration write data
//            ack         - one-cycle pulse after an accepted write
//            frame[8:0]  - payload, LSB first
//            frame_valid - payload request
//            frame_ready - payload can be accepted this cycle
//            Tx          - serial line, idle high
//            busy        - a frame is on the line
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic       valid,
  input  logic [3:0] address,
  input  logic [3:0] data,
  output logic       ack,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  output logic       frame_ready,
  output logic       Tx,
  output logic       busy
);

  // Tick counter must reach 2*OVERSAMPLE-1 for a two-bit STOP period.
  localparam int           TW            = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] C_BIT_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] C_STOP2_LAST = TW'(2 * OVERSAMPLE - 1);

  localparam logic [3:0] C_ADDR_PAR_EN  = 4'b1001;
  localparam logic [3:0] C_ADDR_PAR_ODD = 4'b1010;
  localparam logic [3:0] C_ADDR_STOP2   = 4'b1011;
  localparam logic [3:0] C_ADDR_LEN     = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          ack_q, ack_d;

  // Live configuration registers
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic          stop2_q, stop2_d;
  logic [3:0]    len_q, len_d;

  // Snapshot taken when a frame is accepted
  logic [8:0]    frm_q, frm_d;
  logic [3:0]    frm_len_q, frm_len_d;
  logic          frm_par_en_q, frm_par_en_d;
  logic          frm_par_q, frm_par_d;
  logic          frm_stop2_q, frm_stop2_d;

  logic          w_cfg_hit;
  logic          w_cfg_acc;
  logic          w_frm_acc;
  logic [3:0]    w_len_wr;
  logic [8:0]    w_data_mask;
  logic          w_parity;
  logic          w_tick_last;
  logic [3:0]    w_bit_next;

  assign w_cfg_hit = (address == C_ADDR_PAR_EN) || (address == C_ADDR_PAR_ODD) ||
                     (address == C_ADDR_STOP2)  || (address == C_ADDR_LEN);
  assign w_cfg_acc = (state_q == S_IDLE) && valid && w_cfg_hit;
  assign w_frm_acc = frame_ready && frame_valid;

  // 5 + data, saturating at 9
  assign w_len_wr = (data >= 4'd4) ? 4'd9 : (4'd5 + data);

  // Parity is computed once at acceptance over only the bits that will be sent.
  assign w_data_mask = 9'h1FF >> (4'd9 - len_q);
  assign w_parity    = (^(frame & w_data_mask)) ^ par_odd_q;

  assign w_tick_last = (state_q == S_STOP)
                     ? (tick_q == (frm_stop2_q ? C_STOP2_LAST : C_BIT_LAST))
                     : (tick_q == C_BIT_LAST);
  assign w_bit_next  = bit_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q + 1'b1;
    bit_d        = bit_q;
    tx_d         = tx_q;
    ack_d        = 1'b0;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    stop2_d      = stop2_q;
    len_d        = len_q;
    frm_d        = frm_q;
    frm_len_d    = frm_len_q;
    frm_par_en_d = frm_par_en_q;
    frm_par_d    = frm_par_q;
    frm_stop2_d  = frm_stop2_q;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (w_cfg_acc) begin
          ack_d = 1'b1;
          case (address)
            C_ADDR_PAR_EN:  par_en_d  = data[3];
            C_ADDR_PAR_ODD: par_odd_d = data[3];
            C_ADDR_STOP2:   stop2_d   = data[3];
            default:        len_d     = w_len_wr;
          endcase
        end else if (w_frm_acc) begin
          state_d      = S_START;
          tx_d         = 1'b0;
          frm_d        = frame;
          frm_len_d    = len_q;
          frm_par_en_d = par_en_q;
          frm_par_d    = w_parity;
          frm_stop2_d  = stop2_q;
        end
      end
      S_START: begin
        if (w_tick_last) begin
          state_d = S_DATA;
          tick_d  = '0;
          tx_d    = frm_q[0];
        end
      end
      S_DATA: begin
        if (w_tick_last) begin
          tick_d = '0;
          if (bit_q == (frm_len_q - 4'd1)) begin
            bit_d = '0;
            if (frm_par_en_q) begin
              state_d = S_PARITY;
              tx_d    = frm_par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = w_bit_next;
            tx_d  = frm_q[w_bit_next];
          end
        end
      end
      S_PARITY: begin
        if (w_tick_last) begin
          state_d = S_STOP;
          tick_d  = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick_last) begin
          state_d = S_IDLE;
          tick_d  = '0;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      tx_q         <= 1'b1;
      ack_q        <= 1'b0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      len_q        <= 4'd8;
      frm_q        <= '0;
      frm_len_q    <= 4'd8;
      frm_par_en_q <= 1'b0;
      frm_par_q    <= 1'b0;
      frm_stop2_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      ack_q        <= ack_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      stop2_q      <= stop2_d;
      len_q        <= len_d;
      frm_q        <= frm_d;
      frm_len_q    <= frm_len_d;
      frm_par_en_q <= frm_par_en_d;
      frm_par_q    <= frm_par_d;
      frm_stop2_q  <= frm_stop2_d;
    end
  end

  assign Tx          = tx_q;
  assign ack         = ack_q;
  assign busy        = (state_q != S_IDLE);
  // A configuration strobe blocks payload acceptance in the same cycle.
  assign frame_ready = (state_q == S_IDLE) && !valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Scoreboard bench for uart_transmitter. Stimulus pushes the
//            expected line waveform of each frame; a monitor captures Tx for
//            every busy period and compares it bit-period by bit-period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

  localparam int OS = 16;

  logic       clk_16bd = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] address = '0;
  logic [3:0] data = '0;
  logic       ack;
  logic [8:0] frame = '0;
  logic       frame_valid = 1'b0;
  logic       frame_ready;
  logic       Tx;
  logic       busy;

  uart_transmitter #(.OVERSAMPLE(OS)) dut (
    .clk_16bd   (clk_16bd),
    .rst        (rst),
    .valid      (valid),
    .address    (address),
    .data       (data),
    .ack        (ack),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .Tx         (Tx),
    .busy       (busy)
  );

  always #5 clk_16bd = ~clk_16bd;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_pen, m_podd, m_stop2;
  int m_len;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
  } exp_t;

  exp_t sb[$];

  function automatic void model_reset();
    m_pen = 0; m_podd = 0; m_stop2 = 0; m_len = 8;
  endfunction

  function automatic bit known(input logic [3:0] a);
    return a inside {4'd9, 4'd10, 4'd11, 4'd12};
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [3:0] d);
    int t;
    t = 5 + int'(d);
    case (a)
      4'd9:  m_pen   = d[3];
      4'd10: m_podd  = d[3];
      4'd11: m_stop2 = d[3];
      4'd12: m_len   = (t > 9) ? 9 : t;
      default: ;
    endcase
  endfunction

  // Line bit sequence: start 0, m_len data bits LSB first, optional parity, stop 1s.
  function automatic exp_t model(input logic [8:0] f);
    exp_t e;
    logic p;
    e.nbits = 0;
    e.bits  = '0;
    p = m_podd;
    e.bits[e.nbits] = 1'b0; e.nbits++;
    for (int i = 0; i < m_len; i++) begin
      e.bits[e.nbits] = f[i];
      p = p ^ f[i];
      e.nbits++;
    end
    if (m_pen) begin e.bits[e.nbits] = p; e.nbits++; end
    e.bits[e.nbits] = 1'b1; e.nbits++;
    if (m_stop2) begin e.bits[e.nbits] = 1'b1; e.nbits++; end
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit   in_frame = 0;
  bit   aborted = 0;
  int   cnt, werr, first_err;
  exp_t cur;

  always @(negedge clk_16bd) begin
    if (busy) begin
      if (!in_frame) begin
        in_frame  = 1;
        cnt       = 0;
        werr      = 0;
        first_err = -1;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_frame: busy rose with no frame expected (t=%0t)", $time);
          cur.nbits = 0;
          cur.bits  = '0;
        end else begin
          cur = sb.pop_front();
        end
      end
      if (cnt < cur.nbits * OS) begin
        if (Tx !== cur.bits[cnt / OS]) begin
          werr++;
          if (first_err < 0) first_err = cnt;
        end
      end
      cnt++;
    end else if (in_frame) begin
      in_frame = 0;
      if (aborted) begin
        aborted = 0;
      end else begin
        check("busy_len", cnt, cur.nbits * OS);
        if (werr != 0)
          $display("  first Tx difference at busy cycle %0d", first_err);
        check("tx_wave_bad_cycles", werr, 0);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic cfg_write(input logic [3:0] a, input logic [3:0] d, input bit idle);
    bit exp_ack;
    exp_ack = idle && known(a);
    @(posedge clk_16bd); #1;
    valid = 1'b1; address = a; data = d;
    @(posedge clk_16bd); #1;
    valid = 1'b0;
    check("ack", int'(ack), int'(exp_ack));
    if (exp_ack) model_write(a, d);
    @(posedge clk_16bd); #1;
    check("ack_one_cycle", int'(ack), 0);
  endtask

  task automatic send(input logic [8:0] f);
    int w;
    bit ok;
    w = 0; ok = 0;
    while (!ok && w < 600) begin
      @(posedge clk_16bd); #1;
      if (frame_ready && !busy) ok = 1;
      w++;
    end
    if (!ok) begin
      check("ready_timeout", 0, 1);
    end else begin
      frame_valid = 1'b1;
      frame = f;
      sb.push_back(model(f));
      @(posedge clk_16bd); #1;
      frame_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (busy && w < 600) begin
      @(posedge clk_16bd); #1;
      w++;
    end
    if (busy) check("done_timeout", 1, 0);
  endtask

  task automatic do_reset(input bit mid);
    @(posedge clk_16bd); #2;
    if (mid) aborted = 1;
    rst = 1'b0;
    #1;
    check("rst_tx", int'(Tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_ready", int'(frame_ready), 1);
    repeat (2) @(posedge clk_16bd);
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic count_busy(input int n, output int nb);
    nb = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_16bd); #1;
      if (busy) nb++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nb;
    int nw;
    model_reset();
    #12;
    check("reset_tx", int'(Tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_ack", int'(ack), 0);
    check("reset_ready", int'(frame_ready), 1);
    @(posedge clk_16bd); #2;
    rst = 1'b1;

    // Default configuration, 8N1
    send(9'h0A5); wait_done();

    // Even parity
    do_reset(0);
    cfg_write(4'b1001, 4'b1000, 1);
    cfg_write(4'b1010, 4'b0000, 1);
    send(9'h007); wait_done();

    // Nine bits, two stop bits
    do_reset(0);
    cfg_write(4'b1100, 4'h4, 1);
    cfg_write(4'b1011, 4'b1000, 1);
    send(9'h1FF); wait_done();

    // Saturated length, odd parity
    do_reset(0);
    cfg_write(4'b1100, 4'hF, 1);
    cfg_write(4'b1001, 4'b1000, 1);
    cfg_write(4'b1010, 4'b1000, 1);
    send(9'h000); wait_done();

    // Writes and payloads while busy are dropped
    do_reset(0);
    send(9'h0A5);
    repeat (20) @(posedge clk_16bd);
    cfg_write(4'b1001, 4'b1000, 0);
    @(posedge clk_16bd); #1;
    frame_valid = 1'b1; frame = 9'h155;
    @(posedge clk_16bd); #1;
    frame_valid = 1'b0;
    wait_done();
    count_busy(40, nb);
    check("no_queued_frame", nb, 0);
    send(9'h0A5); wait_done();   // parity must still be off

    // valid wins over frame_valid in IDLE
    @(posedge clk_16bd); #1;
    valid = 1'b1; address = 4'b1001; data = 4'b1000;
    frame_valid = 1'b1; frame = 9'h0F3;
    @(posedge clk_16bd); #1;
    valid = 1'b0; frame_valid = 1'b0;
    check("ack_with_frame_valid", int'(ack), 1);
    model_write(4'b1001, 4'b1000);
    count_busy(20, nb);
    check("no_frame_with_valid", nb, 0);

    // Back-to-back frames
    send(9'($urandom)); send(9'($urandom)); wait_done();

    // Randomized configuration and payloads
    for (int k = 0; k < 12; k++) begin
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++)
        cfg_write(4'($urandom_range(8, 15)), 4'($urandom_range(0, 15)), 1);
      send(9'($urandom));
      if (k % 3 == 0) send(9'($urandom));
      wait_done();
    end

    // Reset in the middle of DATA, then defaults restored
    do_reset(0);
    cfg_write(4'b1100, 4'h3, 1);
    do_reset(0);
    send(9'h0A5);
    repeat (16 + 16 * 3 + 7) @(posedge clk_16bd);
    do_reset(1);
    send(9'h0A5); wait_done();

    repeat (20) @(posedge clk_16bd);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
